// File: rtl/div_sched_pkg.sv
// div_sched_pkg
//   Shared definitions for div_job_scheduler: FSM state encodings, default
//   datapath widths of the ROM-fed restoring divider, and the address
//   stride between consecutive jobs (operand A at 2*i, operand B at 2*i+1).
package div_sched_pkg;

    localparam int unsigned ADDR_W_DEF  = 9;
    localparam int unsigned Q_W_DEF     = 8;
    localparam int unsigned R_W_DEF     = 9;
    localparam int unsigned ADDR_STRIDE = 2;

    // Fixed encodings so the state register matches the legacy netlist.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_WAIT   = ST_WAIT,
        S_EMIT   = ST_EMIT,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/div_job_scheduler.sv
// div_job_scheduler
//   Runs a batch of divide jobs through a single restoring divider. Each job
//   presents an operand address pair, restarts the divider through div_rst,
//   waits for div_finished (or a timeout) and offers the result on a
//   valid/ready stream.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start             : batch request, sampled only when idle
//   base_addr         : address of job 0 operand A (sampled with start)
//   job_count         : number of jobs in the batch (sampled with start)
//   div_rst           : divider reset; high while idle, launching or emitting
//   div_addr_a/b      : operand addresses for the current job
//   div_quotient      : divider quotient
//   div_remainder     : divider remainder
//   div_finished      : divider done flag
//   res_valid/ready   : result handshake
//   res_quotient      : captured quotient (0 on timeout)
//   res_remainder     : captured remainder (0 on timeout)
//   res_index         : 0-based job number of the result
//   res_timeout       : job was abandoned after TIMEOUT wait cycles
//   busy              : batch in progress
//   done              : one-cycle pulse at batch end
module div_job_scheduler
    import div_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned Q_W        = Q_W_DEF,
    parameter int unsigned R_W        = R_W_DEF,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        job_count,
    output logic              div_rst,
    output logic [ADDR_W-1:0] div_addr_a,
    output logic [ADDR_W-1:0] div_addr_b,
    input  logic [Q_W-1:0]    div_quotient,
    input  logic [R_W-1:0]    div_remainder,
    input  logic              div_finished,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [Q_W-1:0]    res_quotient,
    output logic [R_W-1:0]    res_remainder,
    output logic [7:0]        res_index,
    output logic              res_timeout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SUM_W = ADDR_W + 9;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        count_q;
    logic [7:0]        index_q;
    logic [7:0]        rst_cnt;
    logic [7:0]        wait_cnt;

    // Operand address of job idx: base + stride*idx (+1 for operand B),
    // wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] job_addr(
        input logic [ADDR_W-1:0] b,
        input logic [7:0]        idx,
        input logic              odd
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(b) + SUM_W'(ADDR_STRIDE) * SUM_W'(idx) + SUM_W'(odd);
        return sum[ADDR_W-1:0];
    endfunction

    // The job index register doubles as the result index: it only advances
    // after the result has been transferred.
    assign res_index = index_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            base_q        <= '0;
            count_q       <= '0;
            index_q       <= '0;
            rst_cnt       <= '0;
            wait_cnt      <= '0;
            div_rst       <= 1'b1;
            div_addr_a    <= '0;
            div_addr_b    <= '0;
            res_valid     <= 1'b0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_timeout   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_rst <= 1'b1;
                    done    <= 1'b0;
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= job_count;
                        index_q <= '0;
                        busy    <= 1'b1;
                        if (job_count == 8'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_LAUNCH;
                            rst_cnt    <= '0;
                            div_addr_a <= job_addr(base_addr, 8'd0, 1'b0);
                            div_addr_b <= job_addr(base_addr, 8'd0, 1'b1);
                        end
                    end
                end

                S_LAUNCH: begin
                    // div_rst stays high for exactly RST_CYCLES cycles here.
                    if (rst_cnt == 8'(RST_CYCLES - 1)) begin
                        state    <= S_WAIT;
                        div_rst  <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end

                S_WAIT: begin
                    // A finish on the timeout cycle still counts as a result.
                    if (div_finished) begin
                        res_quotient  <= div_quotient;
                        res_remainder <= div_remainder;
                        res_timeout   <= 1'b0;
                        res_valid     <= 1'b1;
                        div_rst       <= 1'b1;
                        state         <= S_EMIT;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        res_quotient  <= '0;
                        res_remainder <= '0;
                        res_timeout   <= 1'b1;
                        res_valid     <= 1'b1;
                        div_rst       <= 1'b1;
                        state         <= S_EMIT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (index_q + 8'd1 == count_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            index_q    <= index_q + 8'd1;
                            rst_cnt    <= '0;
                            div_addr_a <= job_addr(base_q, index_q + 8'd1, 1'b0);
                            div_addr_b <= job_addr(base_q, index_q + 8'd1, 1'b1);
                            state      <= S_LAUNCH;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    div_rst <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_job_scheduler.md
# div_job_scheduler

Sequencer that runs a batch of divide jobs through the ROM-fed restoring divider (9-bit operand addresses, 8-bit quotient, 9-bit remainder, `finished` flag). For each job it presents an operand address pair, pulses the divider's reset to restart it, and waits for `finished` or a timeout. It then delivers the result on a valid/ready stream. It sits between the system control logic and the single divider instance.

## Interface
- `ADDR_W`, 9: divider ROM address width.
- `Q_W`, 8: quotient width.
- `R_W`, 9: remainder width.
- `RST_CYCLES`, 2: cycles `div_rst` is held high per launch (≥1).
- `TIMEOUT`, 255: maximum WAIT cycles before a job is abandoned (≥1, fits 8 bits).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle batch request; sampled only in IDLE.
- `base_addr` in ADDR_W: address of job 0 operand A; sampled with `start`.
- `job_count` in 8: number of jobs; sampled with `start`.
- `div_rst` out 1: reset to divider.
- `div_addr_a` out ADDR_W: divider `addressA`.
- `div_addr_b` out ADDR_W: divider `addressB`.
- `div_quotient` in Q_W: divider quotient.
- `div_remainder` in R_W: divider remainder.
- `div_finished` in 1: divider done.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `res_quotient` out Q_W: captured quotient.
- `res_remainder` out R_W: captured remainder.
- `res_index` out 8: job number, 0-based.
- `res_timeout` out 1: job timed out; quotient and remainder forced to 0.
- `busy` out 1: batch in progress.
- `done` out 1: one-cycle pulse at batch end.

## Operation
- States: IDLE, LAUNCH, WAIT, EMIT, DONE.
- IDLE: `div_rst`=1, so the divider is held in reset. On `start`: latch `base_addr` and `job_count`, set index=0.
  - If `job_count`=0, go to DONE.
  - Otherwise go to LAUNCH.
- LAUNCH: drive `div_addr_a` = base+2·index and `div_addr_b` = base+2·index+1. Both are computed mod 2^ADDR_W, so they wrap without error. Hold `div_rst`=1 for RST_CYCLES cycles, then go to WAIT.
- WAIT: `div_rst`=0, addresses held stable.
  - `div_finished`=1: capture quotient and remainder, `res_timeout`=0, go to EMIT.
  - Otherwise, after TIMEOUT WAIT cycles: capture zeros, `res_timeout`=1, go to EMIT.
  - If `div_finished` rises on the same cycle as the timeout, it wins.
- EMIT: `res_valid`=1. Data, index and timeout flag stay stable until the cycle where `res_valid`&`res_ready` transfers. After transfer:
  - If index+1 = job_count, go to DONE.
  - Otherwise increment index and go to LAUNCH.
- In EMIT, `div_rst`=1, so the divider is parked.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `busy`=1 in LAUNCH, WAIT, EMIT and DONE.
- `start` outside IDLE is ignored; there is no queueing.
- `rst` mid-batch aborts immediately. The batch is not resumed, and any pending result is dropped.
- Reset values: state IDLE, `div_rst`=1, addresses 0, `res_valid`=0, result fields 0, `res_index`=0, `res_timeout`=0, `busy`=0, `done`=0.

## Timing
- `start` at edge t: LAUNCH from t+1, with addresses valid at t+1.
- `div_rst` is high from t+1 through t+RST_CYCLES; WAIT begins at t+RST_CYCLES+1.
- `div_finished` sampled high at WAIT edge w gives `res_valid`=1 from w+1.
- Transfer at edge e:
  - next job's LAUNCH at e+1, or
  - DONE at e+1 with `done` high during cycle e+1, and IDLE at e+2.
- Minimum per-job overhead beyond divider latency: RST_CYCLES+2 cycles.
- All outputs are registered; no combinational path from `res_ready` or `div_finished` to any output.

## Structure
- Package `div_sched_pkg`: state enum (IDLE, LAUNCH, WAIT, EMIT, DONE), default widths ADDR_W/Q_W/R_W, and the address-stride constant 2.
- One module. The launch/timeout counter stays inline; no sub-module is warranted.
- The top-level integration instantiates this block plus the divider.

## Test plan
- Divider model, latency 12; ROM[0]=100, ROM[1]=7; base=0, count=1: one result, q=14, r=2, index 0, timeout 0; `done` one cycle after transfer.
- count=3, base=4, `res_ready` tied 1: addresses (4,5), (6,7), (8,9) in order; indexes 0, 1, 2; exactly one `done`.
- base=510, count=2: job 1 addresses wrap to (0,1); job 0 uses (510,511).
- Divider never asserts finished, TIMEOUT=20: result after 20 WAIT cycles with timeout=1, q=0, r=0; next job launches normally.
- `res_ready` held low for 10 cycles in EMIT:
  - `res_valid` and data stay stable;
  - `start` pulses meanwhile are ignored;
  - `div_rst` stays 1.
- count=0 → `done` at t+1, no `res_valid`. Then `rst` asserted during WAIT of job 1 of 3 → all outputs reach reset values immediately, with no further results.
